bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 15 +
 rtl/bus_watchdog.sv | 45 ++++
 rtl/bus_arbiter.sv | 120 ++++++++++++
 tb/tb_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types for the alternate-master bus arbiter: FSM state encoding and master-count limit.
// No logic; imported by bus_arbiter and bus_watchdog.
package bus_arbiter_pkg;

    localparam int MAX_REQ = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_BUS = 3'd2,
        OWNED    = 3'd3,
        RELEASE  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/bus_watchdog.sv
// Bus-cycle watchdog: asserts BERRn when a CPU strobe runs TIMEOUT_CYCLES without termination.
// Latency: BERRn falls one cycle after the counter sits at its limit.
// Backpressure: none; BERRn is held until ASn returns high.
module bus_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       CLK,
    input  logic       RESET_INn,
    input  logic       ASn,
    input  logic [1:0] DSACKn,
    input  logic       STERMn,
    input  logic       owned,
    output logic       BERRn
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic             term;

    assign term = (DSACKn != 2'b11) || !STERMn;

    // Counter saturates at CNT_MAX; while an alternate master owns the bus it holds.
    always_ff @(posedge CLK or negedge RESET_INn) begin
        if (!RESET_INn) begin
            cnt   <= '0;
            BERRn <= 1'b1;
        end else if (ASn) begin
            cnt   <= '0;
            BERRn <= 1'b1;
        end else if (term) begin
            cnt <= '0;
        end else if (!owned) begin
            if (cnt == CNT_MAX) begin
                BERRn <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter handing the CPU bus to NUM_REQ alternate masters (BR/BG/BGACK handshake).
// Latency: grant 3 cycles after request at best; watchdog built only with BUS_TIMEOUT_EN.
// Backpressure: losers stay pending on REQn; owner keeps the bus until it raises REQn.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               CLK,
    input  logic               RESET_INn,
    input  logic [NUM_REQ-1:0] REQn,
    output logic [NUM_REQ-1:0] GNTn,
    output logic               BRn,
    input  logic               BGn,
    output logic               BGACKn,
    input  logic               ASn,
    input  logic               RMCn,
    input  logic [1:0]         DSACKn,
    input  logic               STERMn,
    output logic               BERRn
);

    localparam int WW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t    state;
    logic [WW-1:0] winner;
    logic [WW-1:0] last_winner;
    logic [WW-1:0] pick;
    logic          found;
    int            idx;

    // Search starts one past the previous owner so every master gets a turn.
    always_comb begin
        pick  = last_winner;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ && k <= MAX_REQ; k++) begin
            idx = (int'(last_winner) + k) % NUM_REQ;
            if (!found && !REQn[WW'(idx)]) begin
                pick  = WW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_INn) begin
        if (!RESET_INn) begin
            state       <= IDLE;
            winner      <= '0;
            last_winner <= WW'(NUM_REQ - 1);
            BRn         <= 1'b1;
            BGACKn      <= 1'b1;
            GNTn        <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        winner <= pick;
                        state  <= REQ;
                        BRn    <= 1'b0;
                    end
                end
                REQ: begin
                    // A withdrawn request abandons the attempt without touching fairness.
                    if (REQn[winner]) begin
                        state <= IDLE;
                        BRn   <= 1'b1;
                    end else if (!BGn) begin
                        state <= WAIT_BUS;
                    end
                end
                WAIT_BUS: begin
                    if (ASn && RMCn) begin
                        state       <= OWNED;
                        BRn         <= 1'b1;
                        BGACKn      <= 1'b0;
                        GNTn        <= ~(NUM_REQ'(1) << winner);
                        last_winner <= winner;
                    end
                end
                OWNED: begin
                    if (REQn[winner]) begin
                        state  <= RELEASE;
                        BGACKn <= 1'b1;
                        GNTn   <= '1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    BRn    <= 1'b1;
                    BGACKn <= 1'b1;
                    GNTn   <= '1;
                end
            endcase
        end
    end

`ifdef BUS_TIMEOUT_EN
    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK       (CLK),
        .RESET_INn (RESET_INn),
        .ASn       (ASn),
        .DSACKn    (DSACKn),
        .STERMn    (STERMn),
        .owned     (state == OWNED),
        .BERRn     (BERRn)
    );
`else
    logic unused_term;
    assign unused_term = &{1'b0, DSACKn, STERMn};
    assign BERRn       = 1'b1;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against a cycle-level behavioural model.
module tb_bus_arbiter;

    localparam int N   = 2;
    localparam int TMO = 64;

    logic         CLK       = 1'b0;
    logic         RESET_INn = 1'b1;
    logic [N-1:0] REQn      = '1;
    logic         BGn       = 1'b1;
    logic         ASn       = 1'b1;
    logic         RMCn      = 1'b1;
    logic [1:0]   DSACKn    = 2'b11;
    logic         STERMn    = 1'b1;
    logic [N-1:0] GNTn;
    logic         BRn;
    logic         BGACKn;
    logic         BERRn;

    int n_chk = 0;
    int n_bad = 0;

    // Model: phase 0 idle, 1 bus requested, 2 bus granted/awaiting idle, 3 owned, 4 release.
    int   m_phase;
    int   m_tgt;
    int   m_last;
    int   m_cnt;
    logic m_berr_n;

    bus_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK       (CLK),
        .RESET_INn (RESET_INn),
        .REQn      (REQn),
        .GNTn      (GNTn),
        .BRn       (BRn),
        .BGn       (BGn),
        .BGACKn    (BGACKn),
        .ASn       (ASn),
        .RMCn      (RMCn),
        .DSACKn    (DSACKn),
        .STERMn    (STERMn),
        .BERRn     (BERRn)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last_w, input logic [N-1:0] rq_n);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last_w + k) % N;
            if (!rq_n[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_tgt    = 0;
        m_last   = N - 1;
        m_cnt    = 0;
        m_berr_n = 1'b1;
    endtask

    task automatic model_step();
        int nxt;
        nxt = m_phase;
`ifdef BUS_TIMEOUT_EN
        if (ASn) begin
            m_cnt    = 0;
            m_berr_n = 1'b1;
        end else if (DSACKn != 2'b11 || !STERMn) begin
            m_cnt = 0;
        end else if (m_phase != 3) begin
            if (m_cnt >= TMO) m_berr_n = 1'b0;
            else m_cnt++;
        end
`endif
        case (m_phase)
            0: if (rr_pick(m_last, REQn) >= 0) begin
                   m_tgt = rr_pick(m_last, REQn);
                   nxt   = 1;
               end
            1: if (REQn[m_tgt]) nxt = 0;
               else if (!BGn) nxt = 2;
            2: if (ASn && RMCn) begin
                   nxt    = 3;
                   m_last = m_tgt;
               end
            3: if (REQn[m_tgt]) nxt = 4;
            default: nxt = 0;
        endcase
        m_phase = nxt;
    endtask

    task automatic compare_all();
        logic [N-1:0] exp_gnt;
        exp_gnt = '1;
        if (m_phase == 3) exp_gnt[m_tgt] = 1'b0;
        chk("gnt", 32'(GNTn), 32'(exp_gnt));
        chk("br", 32'(BRn), 32'(!(m_phase == 1 || m_phase == 2)));
        chk("bgack", 32'(BGACKn), 32'(m_phase != 3));
        chk("berr", 32'(BERRn), 32'(m_berr_n));
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        compare_all();
    endtask

    // Called at a falling edge: reset lands mid-cycle, outputs must drop without a clock.
    task automatic do_reset();
        #2 RESET_INn = 1'b0;
        model_reset();
        #1;
        chk("arst_bgack", 32'(BGACKn), 32'd1);
        chk("arst_gnt", 32'(GNTn), 32'(2'b11));
        chk("arst_br", 32'(BRn), 32'd1);
        chk("arst_berr", 32'(BERRn), 32'd1);
        @(negedge CLK);
        RESET_INn = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 RESET_INn = 1'b0;
        #2;
        chk("rst_gnt", 32'(GNTn), 32'(2'b11));
        chk("rst_br", 32'(BRn), 32'd1);
        chk("rst_bgack", 32'(BGACKn), 32'd1);
        chk("rst_berr", 32'(BERRn), 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        RESET_INn = 1'b1;
        tick();

        // Minimum-latency grant to master 0
        REQn = 2'b10;
        tick();
        chk("lat_br_low", 32'(BRn), 32'd0);
        BGn = 1'b0;
        tick();
        chk("lat_bgack_wait", 32'(BGACKn), 32'd1);
        tick();
        chk("lat_gnt", 32'(GNTn), 32'(2'b10));
        chk("lat_bgack", 32'(BGACKn), 32'd0);
        chk("lat_br_high", 32'(BRn), 32'd1);
        REQn = 2'b11;
        BGn  = 1'b1;
        tick();
        chk("rel_bgack", 32'(BGACKn), 32'd1);
        chk("rel_gnt", 32'(GNTn), 32'(2'b11));
        tick();

        // Both masters held low: 0 first, then 1 after its release
        do_reset();
        REQn = 2'b00;
        BGn  = 1'b0;
        tick();
        tick();
        tick();
        chk("rr_first", 32'(GNTn), 32'(2'b10));
        repeat (3) tick();
        REQn = 2'b01;
        tick();
        chk("rr_release", 32'(BGACKn), 32'd1);
        REQn = 2'b00;
        repeat (3) tick();
        chk("rr_second_wait", 32'(GNTn), 32'(2'b11));
        tick();
        chk("rr_second", 32'(GNTn), 32'(2'b01));
        chk("rr_second_bgack", 32'(BGACKn), 32'd0);

        // Reset while master 1 owns the bus; no RELEASE cycle afterwards
        do_reset();
        REQn = 2'b11;
        BGn  = 1'b1;
        tick();
        chk("post_rst_idle", 32'(BRn), 32'd1);

        // Request withdrawn before BGn: back to idle, fairness pointer unchanged
        REQn = 2'b10;
        tick();
        chk("drop_br_low", 32'(BRn), 32'd0);
        REQn = 2'b11;
        tick();
        chk("drop_br_high", 32'(BRn), 32'd1);
        tick();
        chk("drop_no_gnt", 32'(GNTn), 32'(2'b11));
        REQn = 2'b00;
        tick();
        BGn = 1'b0;
        tick();
        tick();
        chk("drop_rr_keep", 32'(GNTn), 32'(2'b10));
        REQn = 2'b11;
        tick();
        tick();

        // Bus busy: grant waits until ASn and RMCn are both high
        REQn = 2'b01;
        BGn  = 1'b0;
        ASn  = 1'b0;
        RMCn = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_hold", 32'(BGACKn), 32'd1);
        end
        ASn = 1'b1;
        tick();
        chk("busy_rmc", 32'(BGACKn), 32'd1);
        RMCn = 1'b1;
        tick();
        chk("busy_grant", 32'(BGACKn), 32'd0);
        chk("busy_gnt", 32'(GNTn), 32'(2'b01));
        REQn = 2'b11;
        BGn  = 1'b1;
        tick();
        tick();

        // Watchdog on a stuck CPU cycle
        ASn = 1'b0;
        for (int i = 1; i <= TMO; i++) tick();
        chk("wd_before", 32'(BERRn), 32'd1);
        tick();
`ifdef BUS_TIMEOUT_EN
        chk("wd_fire", 32'(BERRn), 32'd0);
        repeat (40) tick();
        chk("wd_sat", 32'(BERRn), 32'd0);
`else
        chk("wd_absent", 32'(BERRn), 32'd1);
`endif
        ASn = 1'b1;
        tick();
        chk("wd_clear", 32'(BERRn), 32'd1);
        ASn = 1'b0;
        repeat (TMO - 4) tick();
        DSACKn = 2'b10;
        tick();
        DSACKn = 2'b11;
        repeat (10) tick();
        chk("wd_term", 32'(BERRn), 32'd1);
        ASn = 1'b1;
        tick();

        // Random traffic against the model
        for (int c = 0; c < 5000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) REQn[b] = ~REQn[b];
            end
            BGn    = ($urandom_range(1) == 0);
            if ($urandom_range(39) == 0) ASn = ~ASn;
            RMCn   = ($urandom_range(3) != 0);
            DSACKn = ($urandom_range(31) == 0) ? 2'($urandom_range(2)) : 2'b11;
            STERMn = ($urandom_range(31) != 0);
            if ($urandom_range(499) == 0) do_reset();
            else tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
